aes128_key_expansion_fwd: RTL and testbench

Forward AES-128 key schedule, the encrypt-side counterpart of the inverse key expansion.
- On key load, runs a 10-step expansion and latches round key 10. The decrypt key path takes round key 10 as its seed.
- Then serves round keys 0..10 in order to the cipher core, one step per request.
- One shared combinational round-step datapath is time-multiplexed between the initial expansion and the stepping phase.

---
 rtl/aes128_pkg.sv | 56 +++++
 rtl/aes128_key_expansion_fwd_if.sv | 23 ++
 rtl/aes128_key_round.sv | 32 +++
 rtl/aes128_key_expansion_fwd.sv | 123 ++++++++++++
 tb/tb_aes128_key_expansion_fwd.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared AES-128 constants, state enum, S-box and forward rcon helpers
package aes128_pkg;

  localparam int AES128_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } aes_state_e;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] AES128_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes128_sbox(input logic [7:0] x);
    logic [10:0] bit_idx;
    bit_idx = 11'((8'd255 - x)) << 3;
    return AES128_SBOX[bit_idx +: 8];
  endfunction

  function automatic logic [7:0] aes128_rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes128_key_expansion_fwd_if.sv
// rtl/aes128_key_expansion_fwd_if.sv - control and key bus between cipher core and forward key schedule
interface aes128_key_expansion_fwd_if;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         rkey_en;
  logic         rkey_restart;
  logic         key_clear;
  logic         busy;
  logic         key_ready;
  logic [127:0] round_key_out;
  logic [3:0]   round_num_out;
  logic [127:0] round_key_10;

  modport master (
    output key_load, cipher_key, rkey_en, rkey_restart, key_clear,
    input  busy, key_ready, round_key_out, round_num_out, round_key_10
  );

  modport slave (
    input  key_load, cipher_key, rkey_en, rkey_restart, key_clear,
    output busy, key_ready, round_key_out, round_num_out, round_key_10
  );
endinterface

// File: rtl/aes128_key_round.sv
// rtl/aes128_key_round.sv - one combinational forward AES-128 key-schedule step
module aes128_key_round
  import aes128_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, t_w;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};
  assign t_w   = {aes128_sbox(rot_w[31:24]) ^ rcon_in,
                  aes128_sbox(rot_w[23:16]),
                  aes128_sbox(rot_w[15:8]),
                  aes128_sbox(rot_w[7:0])};

  assign n0 = w0 ^ t_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_key_expansion_fwd.sv
// rtl/aes128_key_expansion_fwd.sv - forward AES-128 key schedule: expand to round 10, then serve rounds 0..10
// Optional zeroize on key_clear when AES128_KEY_ZEROIZE_EN is defined.
module aes128_key_expansion_fwd
  import aes128_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_NUM_ROUNDS
)
(
  input  logic                         clk_sys,
  input  logic                         rst,
  aes128_key_expansion_fwd_if.slave    kif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  aes_state_e   state_q, state_d;
  logic [127:0] key_reg_q, key_reg_d;
  logic [127:0] cur_q, cur_d;
  logic [127:0] rk10_q, rk10_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   round_num_q, round_num_d;
  logic         busy_q, busy_d;
  logic         key_ready_q, key_ready_d;

  logic         clear_req;
  logic [3:0]   rcon_idx;
  logic [127:0] step_out;

`ifdef AES128_KEY_ZEROIZE_EN
  assign clear_req = kif.key_clear;
`else
  logic unused_key_clear;
  assign unused_key_clear = kif.key_clear;
  assign clear_req = 1'b0;
`endif

  // The single step datapath follows the expansion counter or the served round index.
  assign rcon_idx = (state_q == EXPAND) ? 4'(cnt_q + 4'd1) : 4'(round_num_q + 4'd1);

  aes128_key_round u_key_round (
    .key_in  (cur_q),
    .rcon_in (aes128_rcon(rcon_idx)),
    .key_out (step_out)
  );

  always_comb begin
    state_d     = state_q;
    key_reg_d   = key_reg_q;
    cur_d       = cur_q;
    rk10_d      = rk10_q;
    cnt_d       = cnt_q;
    round_num_d = round_num_q;

    if (clear_req) begin
      state_d     = IDLE;
      key_reg_d   = '0;
      cur_d       = '0;
      rk10_d      = '0;
      cnt_d       = '0;
      round_num_d = '0;
    end else if (kif.key_load) begin
      state_d   = EXPAND;
      key_reg_d = kif.cipher_key;
      cur_d     = kif.cipher_key;
      cnt_d     = '0;
    end else begin
      case (state_q)
        EXPAND: begin
          cur_d = step_out;
          cnt_d = 4'(cnt_q + 4'd1);
          if (cnt_q == 4'(LAST_IDX - 4'd1)) begin
            rk10_d      = step_out;
            cur_d       = key_reg_q;
            round_num_d = '0;
            state_d     = READY;
          end
        end
        READY: begin
          if (kif.rkey_restart) begin
            cur_d       = key_reg_q;
            round_num_d = '0;
          end else if (kif.rkey_en && (round_num_q < LAST_IDX)) begin
            cur_d       = step_out;
            round_num_d = 4'(round_num_q + 4'd1);
          end
        end
        default: ;
      endcase
    end

    busy_d      = (state_d == EXPAND);
    key_ready_d = (state_d == READY);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= IDLE;
      key_reg_q   <= '0;
      cur_q       <= '0;
      rk10_q      <= '0;
      cnt_q       <= '0;
      round_num_q <= '0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_reg_q   <= key_reg_d;
      cur_q       <= cur_d;
      rk10_q      <= rk10_d;
      cnt_q       <= cnt_d;
      round_num_q <= round_num_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign kif.busy          = busy_q;
  assign kif.key_ready     = key_ready_q;
  assign kif.round_key_out = cur_q;
  assign kif.round_num_out = round_num_q;
  assign kif.round_key_10  = rk10_q;

endmodule

// File: tb/tb_aes128_key_expansion_fwd.sv
// tb/tb_aes128_key_expansion_fwd.sv - directed-vector bench for the forward AES-128 key schedule
module tb_aes128_key_expansion_fwd;

  logic clk_sys = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  logic [127:0] fips_key;
  logic [127:0] seq_key;
  logic [127:0] seq_rk10;
  logic [127:0] fips_rk [0:10];

  aes128_key_expansion_fwd_if kif ();

  aes128_key_expansion_fwd dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .kif     (kif)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_load(input logic [127:0] k);
    kif.cipher_key = k;
    kif.key_load   = 1'b1;
    tick();
    kif.key_load   = 1'b0;
  endtask

  task automatic load_and_wait(input logic [127:0] k);
    pulse_load(k);
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vec_cnt++;
    if (kif.busy !== 1'b0 || kif.key_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_flags: busy=%b key_ready=%b required 0 0", kif.busy, kif.key_ready);
    end
    vec_cnt++;
    if (kif.round_key_out !== 128'h0 || kif.round_key_10 !== 128'h0 || kif.round_num_out !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset_regs: rk=%h rk10=%h num=%0d required all zero",
               kif.round_key_out, kif.round_key_10, kif.round_num_out);
    end
  endtask

  task automatic test_expand();
    bit early;
    pulse_load(fips_key);
    vec_cnt++;
    if (kif.busy !== 1'b1 || kif.key_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL expand_start: busy=%b key_ready=%b required 1 0", kif.busy, kif.key_ready);
    end
    early = 1'b0;
    repeat (9) begin
      tick();
      if (kif.key_ready !== 1'b0 || kif.busy !== 1'b1) early = 1'b1;
    end
    vec_cnt++;
    if (early) begin
      err_cnt++;
      $display("FAIL expand_busy_window: key_ready rose or busy fell before 10 steps, required busy for 10 cycles");
    end
    tick();
    vec_cnt++;
    if (kif.key_ready !== 1'b1 || kif.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL expand_ready: key_ready=%b busy=%b required 1 0", kif.key_ready, kif.busy);
    end
    vec_cnt++;
    if (kif.round_key_10 !== fips_rk[10]) begin
      err_cnt++;
      $display("FAIL expand_rk10: got %h required %h", kif.round_key_10, fips_rk[10]);
    end
    vec_cnt++;
    if (kif.round_num_out !== 4'd0 || kif.round_key_out !== fips_key) begin
      err_cnt++;
      $display("FAIL expand_round0: num=%0d rk=%h required 0 %h", kif.round_num_out, kif.round_key_out, fips_key);
    end
  endtask

  task automatic test_stepping();
    for (int r = 1; r <= 10; r++) begin
      kif.rkey_en = 1'b1;
      tick();
      vec_cnt++;
      if (kif.round_num_out !== 4'(r) || kif.round_key_out !== fips_rk[r]) begin
        err_cnt++;
        $display("FAIL step_round%0d: num=%0d rk=%h required %0d %h",
                 r, kif.round_num_out, kif.round_key_out, r, fips_rk[r]);
      end
    end
    tick();
    kif.rkey_en = 1'b0;
    vec_cnt++;
    if (kif.round_num_out !== 4'd10 || kif.round_key_out !== fips_rk[10]) begin
      err_cnt++;
      $display("FAIL step_hold10: num=%0d rk=%h required 10 %h", kif.round_num_out, kif.round_key_out, fips_rk[10]);
    end
  endtask

  task automatic test_restart();
    kif.rkey_restart = 1'b1;
    tick();
    kif.rkey_restart = 1'b0;
    kif.rkey_en = 1'b1;
    repeat (5) tick();
    kif.rkey_en = 1'b0;
    vec_cnt++;
    if (kif.round_num_out !== 4'd5 || kif.round_key_out !== fips_rk[5]) begin
      err_cnt++;
      $display("FAIL restart_at5: num=%0d rk=%h required 5 %h", kif.round_num_out, kif.round_key_out, fips_rk[5]);
    end
    kif.rkey_en = 1'b1;
    kif.rkey_restart = 1'b1;
    tick();
    kif.rkey_en = 1'b0;
    kif.rkey_restart = 1'b0;
    vec_cnt++;
    if (kif.round_num_out !== 4'd0 || kif.round_key_out !== fips_key) begin
      err_cnt++;
      $display("FAIL restart_priority: num=%0d rk=%h required 0 %h", kif.round_num_out, kif.round_key_out, fips_key);
    end
  endtask

  task automatic test_alt_key();
    load_and_wait(seq_key);
    vec_cnt++;
    if (kif.key_ready !== 1'b1 || kif.round_key_10 !== seq_rk10 || kif.round_key_out !== seq_key) begin
      err_cnt++;
      $display("FAIL alt_key: ready=%b rk10=%h rk=%h required 1 %h %h",
               kif.key_ready, kif.round_key_10, kif.round_key_out, seq_rk10, seq_key);
    end
    kif.rkey_en = 1'b1;
    repeat (10) tick();
    kif.rkey_en = 1'b0;
    vec_cnt++;
    if (kif.round_key_out !== seq_rk10) begin
      err_cnt++;
      $display("FAIL alt_key_step10: got %h required %h", kif.round_key_out, seq_rk10);
    end
  endtask

  task automatic test_reload_in_expand();
    bit early;
    pulse_load(seq_key);
    repeat (4) tick();
    pulse_load(fips_key);
    early = 1'b0;
    repeat (9) begin
      tick();
      if (kif.key_ready !== 1'b0) early = 1'b1;
    end
    vec_cnt++;
    if (early) begin
      err_cnt++;
      $display("FAIL reload_early_ready: key_ready rose before 10 steps after second load, required 0");
    end
    tick();
    vec_cnt++;
    if (kif.key_ready !== 1'b1 || kif.round_key_10 !== fips_rk[10]) begin
      err_cnt++;
      $display("FAIL reload_rk10: ready=%b rk10=%h required 1 %h", kif.key_ready, kif.round_key_10, fips_rk[10]);
    end
  endtask

  task automatic test_reset_in_ready();
    kif.rkey_en = 1'b1;
    repeat (7) tick();
    kif.rkey_en = 1'b0;
    vec_cnt++;
    if (kif.round_num_out !== 4'd7 || kif.round_key_out !== fips_rk[7]) begin
      err_cnt++;
      $display("FAIL pre_reset_round7: num=%0d rk=%h required 7 %h", kif.round_num_out, kif.round_key_out, fips_rk[7]);
    end
    rst = 1'b1;
    kif.rkey_en = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt++;
    if (kif.key_ready !== 1'b0 || kif.busy !== 1'b0 || kif.round_num_out !== 4'd0 ||
        kif.round_key_out !== 128'h0 || kif.round_key_10 !== 128'h0) begin
      err_cnt++;
      $display("FAIL reset_in_ready: ready=%b busy=%b num=%0d rk=%h rk10=%h required all zero",
               kif.key_ready, kif.busy, kif.round_num_out, kif.round_key_out, kif.round_key_10);
    end
    tick();
    kif.rkey_en = 1'b0;
    vec_cnt++;
    if (kif.round_num_out !== 4'd0 || kif.round_key_out !== 128'h0 || kif.key_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_ignores_en: num=%0d rk=%h ready=%b required 0 0 0",
               kif.round_num_out, kif.round_key_out, kif.key_ready);
    end
  endtask

  task automatic test_key_clear();
    load_and_wait(fips_key);
    kif.key_clear = 1'b1;
    tick();
    kif.key_clear = 1'b0;
`ifdef AES128_KEY_ZEROIZE_EN
    vec_cnt++;
    if (kif.key_ready !== 1'b0 || kif.round_key_10 !== 128'h0 || kif.round_key_out !== 128'h0) begin
      err_cnt++;
      $display("FAIL key_clear_zeroize: ready=%b rk10=%h rk=%h required 0 0 0",
               kif.key_ready, kif.round_key_10, kif.round_key_out);
    end
`else
    vec_cnt++;
    if (kif.key_ready !== 1'b1 || kif.round_key_10 !== fips_rk[10] || kif.round_key_out !== fips_key) begin
      err_cnt++;
      $display("FAIL key_clear_ignored: ready=%b rk10=%h rk=%h required 1 %h %h",
               kif.key_ready, kif.round_key_10, kif.round_key_out, fips_rk[10], fips_key);
    end
`endif
  endtask

  initial begin
    fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    seq_key    = 128'h000102030405060708090a0b0c0d0e0f;
    seq_rk10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst              = 1'b1;
    kif.key_load     = 1'b0;
    kif.cipher_key   = '0;
    kif.rkey_en      = 1'b0;
    kif.rkey_restart = 1'b0;
    kif.key_clear    = 1'b0;

    test_reset();
    test_expand();
    test_stepping();
    test_restart();
    test_alt_key();
    test_reload_in_expand();
    test_reset_in_ready();
    test_key_clear();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
